// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and the fetch-queue entry type
//   XLEN          : default address/PC width
//   ILEN          : instruction width
//   NOP_INSTR     : addi x0,x0,0, presented to ID when no instruction is valid
//   fetch_entry_t : {instr, pc} queue entry
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - instruction-memory request/response bus
//   imem_req_valid/ready/addr : fetch request channel (fetch unit -> memory)
//   imem_rsp_valid/data       : in-order response channel (memory -> fetch unit)
//   modport master            : fetch unit side
//   modport slave             : memory side
interface if_fetch_queue_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x WIDTH circular buffer with push/pop/flush
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write an entry at tail
//   pop             : advance head (ignored when empty)
//   flush           : empty the buffer, overrides push/pop
//   head_data       : entry at head
//   count/full/empty: occupancy
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(fetch_entry_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_head];
  assign w_do_pop  = pop && !empty;
  // A push into a full buffer is allowed only when the head frees a slot this cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + AW'(1);
      if (w_do_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_tail] <= push_data;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - RV32I prefetch-queue fetch front end
//   CLK, reset          : clock, asynchronous active-low reset
//   PCSrcE, PCTargetE   : EX-stage redirect request and target
//   imem (master)       : instruction-memory request/response bus
//   StallD              : ID cannot accept this cycle
//   ValidD/InstrD/PCD/PCPlus4D : head instruction presented to ID
//   Optional macro FETCH_QUEUE_BYPASS_EN: forward a response straight to ID
//   when the queue is empty.
module if_fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                PCSrcE,
  input  logic [XLEN-1:0]     PCTargetE,
  if_fetch_queue_if.master    imem,
  input  logic                StallD,
  output logic                ValidD,
  output logic [ILEN-1:0]     InstrD,
  output logic [XLEN-1:0]     PCD,
  output logic [XLEN-1:0]     PCPlus4D
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;
  localparam int EW = ILEN + XLEN;

  logic [XLEN-1:0] r_fpc;
  logic [CW-1:0]   r_live;   // outstanding requests whose responses are kept
  logic [CW-1:0]   r_drop;   // outstanding requests orphaned by a redirect

  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic [EW-1:0]   w_head;
  logic [EW-1:0]   w_rsp_entry;
  logic [EW-1:0]   w_out;
  logic [SW-1:0]   w_credit_used;
  logic [XLEN-1:0] w_rsp_pc;
  logic            w_req_fire;
  logic            w_rsp_live;
  logic            w_rsp_drop;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  // Every queue slot is reserved at request time, so the queue can never overflow.
  assign w_credit_used = SW'(w_count) + SW'(r_live) + SW'(r_drop);
  assign imem.imem_req_valid = reset && !PCSrcE && (w_credit_used < SW'(DEPTH));
  assign imem.imem_req_addr  = r_fpc;
  assign w_req_fire = imem.imem_req_valid && imem.imem_req_ready;

  assign w_rsp_drop = imem.imem_rsp_valid && (r_drop != '0);
  assign w_rsp_live = imem.imem_rsp_valid && (r_drop == '0) && (r_live != '0);
  // Live requests cover fpc-4*live .. fpc-4, so the oldest one is fpc-4*live.
  assign w_rsp_pc    = r_fpc - (XLEN'(r_live) << 2);
  assign w_rsp_entry = {imem.imem_rsp_data, w_rsp_pc};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && w_rsp_live && !PCSrcE;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response that ID takes right away never touches the queue.
  assign w_push = !PCSrcE && w_rsp_live && !(w_bypass && !StallD);
  assign w_pop  = !PCSrcE && !w_empty && !StallD;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (reset),
    .push      (w_push),
    .push_data (w_rsp_entry),
    .pop       (w_pop),
    .flush     (PCSrcE),
    .head_data (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_out  = w_bypass ? w_rsp_entry : w_head;
    ValidD = w_bypass || !w_empty;
    InstrD = ValidD ? w_out[EW-1:XLEN] : NOP_INSTR;
    PCD    = ValidD ? w_out[XLEN-1:0] : '0;
  end

  assign PCPlus4D = PCD + XLEN'(4);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_fpc  <= RESET_PC;
      r_live <= '0;
      r_drop <= '0;
    end else if (PCSrcE) begin
      // Everything still in flight becomes garbage, minus a response landing now.
      r_fpc  <= PCTargetE;
      r_live <= '0;
      r_drop <= r_drop + r_live - CW'(w_rsp_live || w_rsp_drop);
    end else begin
      if (w_req_fire) r_fpc <= r_fpc + XLEN'(4);
      r_live <= r_live + CW'(w_req_fire) - CW'(w_rsp_live);
      if (w_rsp_drop) r_drop <= r_drop - CW'(1);
    end
  end

  a_rsp_expected: assert property (@(posedge CLK) disable iff (!reset)
    imem.imem_rsp_valid |-> (r_live != '0 || r_drop != '0));

  a_no_overflow: assert property (@(posedge CLK) disable iff (!reset)
    w_push |-> (!w_full || w_pop));
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized self-checking bench for if_fetch_queue
module tb_if_fetch_queue;
  import riscv_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        StallD = 1'b0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  if_fetch_queue_if #(.XLEN(32)) bus ();

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .StallD    (StallD),
    .ValidD    (ValidD),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  logic [31:0] mq[$];          // addresses accepted by memory, not yet answered
  logic [31:0] exp_pc;         // next PC ID should receive
  logic [31:0] exp_fetch;      // next address the fetch unit should request
  logic        s_valid, s_req_v, s_rsp;
  logic [31:0] s_pc, s_instr, s_p4, s_req_a;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    reset = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    mq.delete();
    exp_pc = RESET_PC; exp_fetch = RESET_PC;
    #4;
    check("rst_validd", ValidD, 0);
    check("rst_instrd", InstrD, NOP_INSTR);
    check("rst_pcd", PCD, 0);
    check("rst_pcplus4d", PCPlus4D, 4);
    check("rst_req_valid", bus.imem_req_valid, 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    #4;
    check("first_req_valid", bus.imem_req_valid, 1);
    check("first_req_addr", bus.imem_req_addr, RESET_PC);
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, check against the
  // program-order model, then update memory and model for the coming edge.
  task automatic step(input logic stall, input logic rdy, input logic redir,
                      input logic [31:0] tgt, input logic rsp_en);
    logic [31:0] e4;
    @(posedge CLK); #1;
    StallD = stall; bus.imem_req_ready = rdy; PCSrcE = redir; PCTargetE = tgt;
    if (rsp_en && mq.size() != 0) begin
      bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = instr_of(mq[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    end
    #4;
    s_valid = ValidD; s_pc = PCD; s_instr = InstrD; s_p4 = PCPlus4D;
    s_req_v = bus.imem_req_valid; s_req_a = bus.imem_req_addr; s_rsp = bus.imem_rsp_valid;
    if (!s_valid) check("idle_nop", s_instr, NOP_INSTR);
    if (redir) begin
      check("redir_no_req", s_req_v, 0);
      exp_pc = tgt; exp_fetch = tgt;
    end else begin
      if (s_valid && !stall) begin
        e4 = exp_pc + 32'd4;
        check("pcd", s_pc, exp_pc);
        check("instrd", s_instr, instr_of(exp_pc));
        check("pcplus4d", s_p4, e4);
        exp_pc = e4; n_deliv++;
      end
      if (s_req_v && rdy) begin
        check("req_addr", s_req_a, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (s_rsp) void'(mq.pop_front());
    if (!redir && s_req_v && rdy) mq.push_back(s_req_a);
    check("credit", (mq.size() <= DEPTH), 1);
  endtask

  initial begin
    int fr, fv, d0;
    logic [31:0] first_pc;
    logic [31:0] tgt;

    // Free-running requests with no responses: exactly DEPTH requests.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, '0, 0);
      if (i >= DEPTH) check("t1_req_stops", s_req_v, 0);
      check("t1_no_validd", s_valid, 0);
    end
    d0 = n_deliv;
    for (int i = 0; i < 12; i++) step(0, 0, 0, '0, 1);
    check("t1_drained", n_deliv - d0, 4);

    // 1-cycle memory: latency and continuous delivery.
    do_reset();
    fr = -1; fv = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, '0, 1);
      if (fv >= 0) check("t2_continuous", s_valid, 1);
      if (fr < 0 && s_rsp) fr = i;
      if (fv < 0 && s_valid) fv = i;
    end
    check("t2_latency", fv - fr, LAT);

    // Stall fills the queue and stops requests; release drains 4 in order.
    for (int i = 0; i < 8; i++) step(1, 1, 0, '0, 1);
    check("t3_req_blocked", s_req_v, 0);
    d0 = n_deliv;
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0);
    check("t3_drain4", n_deliv - d0, 4);

    // Redirect with 3 requests in flight.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 0);
    step(0, 0, 1, 32'h100, 0);
    step(0, 1, 0, '0, 1);
    check("t4_req_valid", s_req_v, 1);
    check("t4_req_addr", s_req_a, 32'h100);
    d0 = n_deliv; first_pc = '1;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, '0, 1);
      if (n_deliv == d0 + 1 && first_pc == '1) first_pc = s_pc;
    end
    check("t4_first_pc", first_pc, 32'h100);

    // Redirect coinciding with a response and a dequeue.
    do_reset();
    step(0, 1, 0, '0, 0);
    step(1, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    step(0, 1, 1, 32'h200, 1);
    check("t5_pre_validd", s_valid, 1);
    check("t5_pre_rsp", s_rsp, 1);
    step(0, 0, 0, '0, 0);
    check("t5_queue_empty", s_valid, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 0, '0, 1);

    // Back-pressure on the request channel holds the address.
    do_reset();
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, '0, 1);
      check("t6_hold_valid", s_req_v, 1);
      check("t6_hold_addr", s_req_a, 32'h8);
    end
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    check("t6_next_addr", s_req_a, 32'hC);

    // Random traffic, including redirects near the top of the address space.
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                        : ($urandom & 32'h0000_FFFC);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, tgt, $urandom_range(0, 9) < 6);
    end
    check("rand_throughput", (n_deliv - d0) > 300, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end for the RV32I 5-stage pipeline. It replaces the fixed single-cycle PC/imem path with a depth-configurable prefetch queue. It talks to instruction memory over a valid/ready request channel with a variable-latency, in-order response, and feeds the ID stage through a valid/stall interface. It owns the fetch PC, absorbs memory latency, and discards in-flight fetches on an EX-stage redirect.

## Interface
Parameters:
- XLEN, 32: address/PC width.
- DEPTH, 4: queue entries; power of two, ≥2. It also bounds in-flight requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- CLK  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- PCSrcE  in  1  redirect request from EX.
- PCTargetE  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid; responses are in request order.
- imem_rsp_data  in  32  fetched instruction.
- StallD  in  1  ID cannot accept this cycle.
- ValidD  out  1  InstrD/PCD valid.
- InstrD  out  32  head instruction; NOP (32'h0000_0013) when ValidD=0.
- PCD  out  XLEN  PC of head instruction.
- PCPlus4D  out  XLEN  PCD+4, wraps mod 2^XLEN.

## Operation
- State:
  - fetch PC (fpc).
  - Circular queue of {instr, pc}, with head/tail/count.
  - live counter: outstanding requests whose responses are kept.
  - drop counter: outstanding requests whose responses are discarded.
  - Both counters are clog2(DEPTH)+1 bits wide.
- Request channel:
  - imem_req_valid = !PCSrcE && (count+live+drop < DEPTH).
  - imem_req_addr = fpc.
  - On handshake, fpc += 4 (wraps) and live increments.
  - Address and valid are held stable until ready is asserted, unless a redirect occurs.
- Response channel:
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise the response is written at tail with pc = the oldest live PC, and live decrements.
  - The oldest live PC is tracked as fpc − 4·live; no PC FIFO is needed.
- Dequeue: occurs when ValidD && !StallD; head advances.
- Redirect (PCSrcE=1), which overrides everything else that cycle:
  - Queue is emptied.
  - fpc ← PCTargetE.
  - drop ← drop + live − (imem_rsp_valid ? 1 : 0).
  - live ← 0.
  - No request is issued.
  - Dequeue and enqueue are ignored in that cycle.
- Simultaneous enqueue and dequeue keeps count unchanged.
- Overflow is impossible by the credit rule. A response with live=drop=0 is a protocol error; it is ignored and flagged by an assertion.
- Reset:
  - fpc=RESET_PC; queue empty; live=drop=0.
  - ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=4.
  - imem_req_valid=0 while reset=0.
  - Reset mid-operation abandons all in-flight responses. The memory must be reset together with this block.

## Timing
- Request issue: first request has imem_req_valid=1 in the first cycle after reset deasserts.
- Response to ID: response at cycle t gives ValidD at t+1 (without bypass).
- Steady state: 1 instruction/cycle with a 1-cycle memory and DEPTH≥2.
- Redirect: PCSrcE at cycle t gives request addr=PCTargetE at t+1. ValidD=0 from t+1 until the first new response +1.
- Redirect and dequeue in the same cycle: ID's FlushD kills the dequeued instruction; the queue must not advance.

## Configuration
- FETCH_QUEUE_BYPASS_EN:
  - Defined: when the queue is empty, drop=0, imem_rsp_valid=1 and PCSrcE=0, the response drives ValidD/InstrD/PCD combinationally in the same cycle. If StallD=0 it is consumed without being written; otherwise it is enqueued.
  - Undefined: all outputs come from registered queue state; 1-cycle response-to-ID latency.

## Structure
- Shared package riscv_pkg holds:
  - XLEN default.
  - ILEN=32.
  - NOP_INSTR=32'h0000_0013.
  - The {instr, pc} entry struct typedef.
- One sub-module, fetch_fifo: a generic DEPTH×entry circular buffer with push, pop, flush, count, full and empty.
- if_fetch_queue holds fpc, the live/drop counters, the credit logic and the bypass.

## Test plan
- Reset, then hold imem_req_ready=1 with no responses (DEPTH=4) → requests to 0x0, 0x4, 0x8, 0xC, then imem_req_valid=0. ValidD stays 0.
- 1-cycle memory, StallD=0 → ValidD continuous. PCD sequence is 0x0, 0x4, 0x8, and PCPlus4D=PCD+4. First ValidD is one cycle after the first response.
- StallD=1 for 8 cycles → count reaches 4 and req_valid drops. Release StallD → 4 instructions drain in order with no loss or duplication.
- With 3 in flight, PCSrcE=1 and PCTargetE=0x100 → the next 3 responses are dropped. Next request addr=0x100. First ValidD has PCD=0x100 and the matching instruction.
- Redirect in the same cycle as imem_rsp_valid, with ValidD=1 and StallD=0 → that response is not enqueued, drop=live−1, and the queue is empty next cycle.
- imem_req_ready=0 for 5 cycles → imem_req_addr is held at 0x8. After acceptance, the next address is 0xC.
